// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB register-init sequencer.
package sccb_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StPwrup,
    StFetch,
    StDecode,
    StWrReq,
    StWrRel,
    StRdReq,
    StRdRel,
    StCheck,
    StDelay,
    StNext,
    StFinish
  } state_e;

  localparam logic [15:0] EndMarker = 16'hFFFF;
  localparam logic [7:0]  DelayTag  = 8'hFE;
  localparam int unsigned CntWidth  = 32;

endpackage

// File: rtl/sccb_delay_counter.sv
// Loadable down-counter shared by the power-up wait, table delays and the handshake timeout.
module sccb_delay_counter
  import sccb_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic [CntWidth-1:0] load_val_i,
  input  logic                count_i,
  output logic                expire_o
);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (count_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expires on the last counted cycle, so a load of N spans exactly N cycles.
  assign expire_o = (cnt_q <= CntWidth'(1));

endmodule

// File: rtl/sccb_init_sequencer.sv
// Walks a {sub_addr, value} table and issues SCCB writes, optional readback checks and delays.
module sccb_init_sequencer
  import sccb_pkg::*;
#(
  parameter logic [7:0]  DEV_ID         = 8'h42,
  parameter logic [23:0] PWRUP_CYCLES   = 24'd1_000_000,
  parameter logic [15:0] DELAY_UNIT     = 16'd25_000,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd2_000_000,
  parameter bit          VERIFY         = 1'b1,
  parameter int unsigned MAX_RETRY      = 2
) (
  input  logic        xclk_i,
  input  logic        rst_i,
  input  logic        go_i,
  output logic        busy_o,
  output logic        init_done_o,
  output logic        error_o,
  output logic [7:0]  err_count_o,
  output logic [7:0]  tbl_addr_o,
  input  logic [15:0] tbl_data_i,
  output logic        sccb_start_o,
  output logic        sccb_rw_o,
  output logic [7:0]  sccb_ip_addr_o,
  output logic [7:0]  sccb_sub_addr_o,
  output logic [7:0]  sccb_data_in_o,
  input  logic [7:0]  sccb_data_out_i,
  input  logic        sccb_done_i
);

  localparam logic [CntWidth-1:0] TimeoutVal = CntWidth'(TIMEOUT_CYCLES);

  state_e        state_q, state_d;
  logic [7:0]    tbl_addr_q, tbl_addr_d;
  logic [15:0]   entry_q, entry_d;
  logic          init_done_q, init_done_d;
  logic          error_q, error_d;
  logic [7:0]    err_count_q, err_count_d;
  logic [7:0]    retry_q, retry_d;

  logic                cnt_load, cnt_en, cnt_expire;
  logic [CntWidth-1:0] cnt_load_val;

  sccb_delay_counter u_delay_counter (
    .clk_i      (xclk_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .count_i    (cnt_en),
    .expire_o   (cnt_expire)
  );

  always_comb begin
    state_d      = state_q;
    tbl_addr_d   = tbl_addr_q;
    entry_d      = entry_q;
    init_done_d  = init_done_q;
    error_d      = error_q;
    err_count_d  = err_count_q;
    retry_d      = retry_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (go_i) begin
          tbl_addr_d   = '0;
          init_done_d  = 1'b0;
          error_d      = 1'b0;
          err_count_d  = '0;
          cnt_load     = 1'b1;
          cnt_load_val = CntWidth'(PWRUP_CYCLES);
          state_d      = StPwrup;
        end
      end
      StPwrup: begin
        cnt_en = 1'b1;
        if (cnt_expire) state_d = StFetch;
      end
      StFetch: state_d = StDecode;
      StDecode: begin
        entry_d = tbl_data_i;
        retry_d = '0;
        if (tbl_data_i == EndMarker) begin
          state_d = StFinish;
        end else if (tbl_data_i[15:8] == DelayTag) begin
          if (tbl_data_i[7:0] == 8'h00) begin
            state_d = StNext;
          end else begin
            cnt_load     = 1'b1;
            cnt_load_val = CntWidth'(tbl_data_i[7:0]) * CntWidth'(DELAY_UNIT);
            state_d      = StDelay;
          end
        end else begin
          cnt_load     = 1'b1;
          cnt_load_val = TimeoutVal;
          state_d      = StWrReq;
        end
      end
      StWrReq, StRdReq: begin
        cnt_en = 1'b1;
        if (sccb_done_i) begin
          cnt_load     = 1'b1;
          cnt_load_val = TimeoutVal;
          state_d      = (state_q == StWrReq) ? StWrRel : StRdRel;
        end else if (cnt_expire) begin
          error_d = 1'b1;
          state_d = StFinish;
        end
      end
      StWrRel, StRdRel: begin
        cnt_en = 1'b1;
        if (!sccb_done_i) begin
          if (state_q == StRdRel) begin
            state_d = StCheck;
          end else if (VERIFY) begin
            cnt_load     = 1'b1;
            cnt_load_val = TimeoutVal;
            state_d      = StRdReq;
          end else begin
            state_d = StNext;
          end
        end else if (cnt_expire) begin
          error_d = 1'b1;
          state_d = StFinish;
        end
      end
      StCheck: begin
        state_d = StNext;
        if (sccb_data_out_i != entry_q[7:0]) begin
          if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
          if (32'(retry_q) < MAX_RETRY) begin
            retry_d      = retry_q + 8'd1;
            cnt_load     = 1'b1;
            cnt_load_val = TimeoutVal;
            state_d      = StWrReq;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      StDelay: begin
        cnt_en = 1'b1;
        if (cnt_expire) state_d = StNext;
      end
      StNext: begin
        if (tbl_addr_q == 8'hFF) begin
          state_d = StFinish;
        end else begin
          tbl_addr_d = tbl_addr_q + 8'd1;
          state_d    = StFetch;
        end
      end
      StFinish: begin
        // A slave may still be holding done after a timeout; wait for it to release.
        if (!sccb_done_i) begin
          init_done_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge xclk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      tbl_addr_q  <= '0;
      entry_q     <= '0;
      init_done_q <= 1'b0;
      error_q     <= 1'b0;
      err_count_q <= '0;
      retry_q     <= '0;
    end else begin
      state_q     <= state_d;
      tbl_addr_q  <= tbl_addr_d;
      entry_q     <= entry_d;
      init_done_q <= init_done_d;
      error_q     <= error_d;
      err_count_q <= err_count_d;
      retry_q     <= retry_d;
    end
  end

  assign busy_o          = (state_q != StIdle) && (state_q != StFinish);
  assign init_done_o     = init_done_q;
  assign error_o         = error_q;
  assign err_count_o     = err_count_q;
  assign tbl_addr_o      = tbl_addr_q;
  assign sccb_start_o    = (state_q == StWrReq) || (state_q == StRdReq);
  assign sccb_rw_o       = (state_q == StRdReq) || (state_q == StRdRel);
  assign sccb_ip_addr_o  = sccb_rw_o ? (DEV_ID | 8'h01) : (DEV_ID & 8'hFE);
  assign sccb_sub_addr_o = entry_q[15:8];
  assign sccb_data_in_o  = entry_q[7:0];

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Bench for sccb_init_sequencer: SCCB slave models, table ROMs and a transaction-list reference.
`timescale 1ns/1ps
module tb_sccb_init_sequencer;

  localparam logic [7:0]  DevId    = 8'h42;
  localparam int          Pwrup    = 20;
  localparam int          Du       = 10;
  localparam int          Tmo      = 300;
  localparam int unsigned MaxRetry = 2;

  typedef struct packed {
    logic       rw;
    logic [7:0] ip;
    logic [7:0] sub;
    logic [7:0] data;
  } txn_t;

  logic xclk = 1'b0;
  logic rst;
  always #5 xclk = ~xclk;

  // Instance A: readback verification enabled
  logic        go_a, busy_a, init_done_a, error_a, start_a, rw_a, done_a;
  logic [7:0]  err_count_a, tbl_addr_a, ip_a, sub_a, din_a, dout_a;
  logic [15:0] tbl_data_a;
  // Instance B: write-only
  logic        go_b, busy_b, init_done_b, error_b, start_b, rw_b, done_b;
  logic [7:0]  err_count_b, tbl_addr_b, ip_b, sub_b, din_b;
  logic [15:0] tbl_data_b;

  sccb_init_sequencer #(
    .DEV_ID(DevId), .PWRUP_CYCLES(24'(Pwrup)), .DELAY_UNIT(16'(Du)),
    .TIMEOUT_CYCLES(24'(Tmo)), .VERIFY(1'b1), .MAX_RETRY(MaxRetry)
  ) u_dut_a (
    .xclk_i(xclk), .rst_i(rst), .go_i(go_a), .busy_o(busy_a), .init_done_o(init_done_a),
    .error_o(error_a), .err_count_o(err_count_a), .tbl_addr_o(tbl_addr_a),
    .tbl_data_i(tbl_data_a), .sccb_start_o(start_a), .sccb_rw_o(rw_a), .sccb_ip_addr_o(ip_a),
    .sccb_sub_addr_o(sub_a), .sccb_data_in_o(din_a), .sccb_data_out_i(dout_a),
    .sccb_done_i(done_a)
  );

  sccb_init_sequencer #(
    .DEV_ID(DevId), .PWRUP_CYCLES(24'(Pwrup)), .DELAY_UNIT(16'(Du)),
    .TIMEOUT_CYCLES(24'(Tmo)), .VERIFY(1'b0), .MAX_RETRY(MaxRetry)
  ) u_dut_b (
    .xclk_i(xclk), .rst_i(rst), .go_i(go_b), .busy_o(busy_b), .init_done_o(init_done_b),
    .error_o(error_b), .err_count_o(err_count_b), .tbl_addr_o(tbl_addr_b),
    .tbl_data_i(tbl_data_b), .sccb_start_o(start_b), .sccb_rw_o(rw_b), .sccb_ip_addr_o(ip_b),
    .sccb_sub_addr_o(sub_b), .sccb_data_in_o(din_b), .sccb_data_out_i(8'h00),
    .sccb_done_i(done_b)
  );

  logic [15:0] tbl_a [256];
  logic [15:0] tbl_b [256];
  always @(posedge xclk) tbl_data_a <= tbl_a[tbl_addr_a];
  always @(posedge xclk) tbl_data_b <= tbl_b[tbl_addr_b];

  // Slave A: random handshake latency, register file, optional broken register.
  logic       hang_a, bad_en_a;
  logic [7:0] bad_sub_a;
  logic [2:0] lat_a;
  logic [7:0] mem_a [256];
  txn_t       log_a[$];
  always @(posedge xclk or posedge rst) begin
    if (rst) begin
      done_a <= 1'b0;
      lat_a  <= '0;
      dout_a <= '0;
    end else if (!hang_a) begin
      if (start_a && !done_a) begin
        if (lat_a == 0) begin
          done_a <= 1'b1;
          lat_a  <= 3'($urandom_range(0, 3));
          log_a.push_back({rw_a, ip_a, sub_a, rw_a ? 8'h00 : din_a});
          if (rw_a) dout_a <= (bad_en_a && sub_a == bad_sub_a) ? 8'h00 : mem_a[sub_a];
          else mem_a[sub_a] <= din_a;
        end else lat_a <= lat_a - 3'd1;
      end else if (!start_a && done_a) begin
        if (lat_a == 0) begin
          done_a <= 1'b0;
          lat_a  <= 3'($urandom_range(0, 3));
        end else lat_a <= lat_a - 3'd1;
      end
    end
  end

  // Slave B: done simply follows start one cycle later.
  txn_t log_b[$];
  always @(posedge xclk or posedge rst) begin
    if (rst) done_b <= 1'b0;
    else begin
      done_b <= start_b;
      if (start_b && !done_b) log_b.push_back({rw_b, ip_b, sub_b, rw_b ? 8'h00 : din_b});
    end
  end

  // Bus monitor for A: handshake legality, field stability, idle gaps.
  int   cyc = 0, last_fall_a = 0, rise_cyc_a = 0, proto_err_a = 0;
  int   gap_q[$];
  logic start_prev_a = 1'b0, done_prev_a = 1'b0;
  logic [24:0] held_a = '0;
  always @(posedge xclk) begin
    cyc          <= cyc + 1;
    start_prev_a <= start_a;
    done_prev_a  <= done_a;
    held_a       <= {rw_a, ip_a, sub_a, din_a};
    if (done_prev_a && !done_a) last_fall_a <= cyc;
    if (start_a && !start_prev_a) begin
      gap_q.push_back(cyc - last_fall_a);
      rise_cyc_a <= cyc;
      if (done_a) proto_err_a <= proto_err_a + 1;
    end else if (start_a && held_a != {rw_a, ip_a, sub_a, din_a}) begin
      proto_err_a <= proto_err_a + 1;
    end
  end

  int   n_tests = 0, n_fail = 0;
  txn_t exp_q[$];
  int   exp_errs;
  bit   exp_error;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: expected bus transaction list and error outcome derived from the table rules.
  task automatic model(input logic [15:0] tbl [256], input bit verify, input bit bad_en,
                       input logic [7:0] bad_sub);
    logic [7:0] sub, val, rb;
    exp_q.delete();
    exp_errs  = 0;
    exp_error = 1'b0;
    for (int a = 0; a < 256; a++) begin
      if (tbl[a] == 16'hFFFF) break;
      sub = tbl[a][15:8];
      val = tbl[a][7:0];
      if (sub == 8'hFE) continue;
      for (int t = 0; t <= int'(MaxRetry); t++) begin
        exp_q.push_back({1'b0, DevId & 8'hFE, sub, val});
        if (!verify) break;
        exp_q.push_back({1'b1, DevId | 8'h01, sub, 8'h00});
        rb = (bad_en && sub == bad_sub) ? 8'h00 : val;
        if (rb == val) break;
        if (exp_errs < 255) exp_errs++;
        if (t == int'(MaxRetry)) exp_error = 1'b1;
      end
    end
  endtask

  task automatic clear_tbl_a();
    for (int i = 0; i < 256; i++) tbl_a[i] = 16'hFFFF;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_start"}, 32'(start_a), 32'(0));
    check({tag, "_busy"}, 32'(busy_a), 32'(0));
    check({tag, "_init_done"}, 32'(init_done_a), 32'(0));
    check({tag, "_error"}, 32'(error_a), 32'(0));
    check({tag, "_err_count"}, 32'(err_count_a), 32'(0));
    check({tag, "_tbl_addr"}, 32'(tbl_addr_a), 32'(0));
    check({tag, "_rw"}, 32'(rw_a), 32'(0));
    check({tag, "_sub"}, 32'(sub_a), 32'(0));
    check({tag, "_din"}, 32'(din_a), 32'(0));
    check({tag, "_ip"}, 32'(ip_a), 32'(8'h42));
  endtask

  task automatic wait_init_a(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge xclk);
      if (init_done_a) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_a(input string tag, input bit bad_en, input logic [7:0] bad_sub);
    bit ok;
    bad_en_a  = bad_en;
    bad_sub_a = bad_sub;
    model(tbl_a, 1'b1, bad_en, bad_sub);
    log_a.delete();
    gap_q.delete();
    @(negedge xclk); go_a = 1'b1;
    @(negedge xclk); go_a = 1'b0;
    wait_init_a(4000, ok);
    check({tag, "_finished"}, 32'(ok), 32'(1));
    check({tag, "_busy"}, 32'(busy_a), 32'(0));
    check({tag, "_error"}, 32'(error_a), 32'(exp_error));
    check({tag, "_err_count"}, 32'(err_count_a), 32'(exp_errs));
    check({tag, "_n_txn"}, 32'(log_a.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_a.size(); i++)
      check({tag, "_txn"}, 32'(log_a[i]), 32'(exp_q[i]));
  endtask

  initial begin
    bit ok;
    int g0, g1, el, n;
    go_a = 1'b0; go_b = 1'b0; hang_a = 1'b0; bad_en_a = 1'b0; bad_sub_a = '0;
    rst = 1'b1;
    clear_tbl_a();
    for (int i = 0; i < 256; i++) tbl_b[i] = 16'hFFFF;
    repeat (3) @(negedge xclk);
    check_reset_a("por");
    check("por_b_start", 32'(start_b), 32'(0));
    rst = 1'b0;

    // Write-only table: two writes in order, then done without error.
    tbl_b[0] = 16'h1280;
    tbl_b[1] = 16'h1101;
    model(tbl_b, 1'b0, 1'b0, 8'h00);
    @(negedge xclk); go_b = 1'b1;
    @(negedge xclk); go_b = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge xclk);
      ok = init_done_b;
    end
    check("nv_finished", 32'(ok), 32'(1));
    check("nv_error", 32'(error_b), 32'(0));
    check("nv_n_txn", 32'(log_b.size()), 32'(2));
    for (int i = 0; i < exp_q.size() && i < log_b.size(); i++)
      check("nv_txn", 32'(log_b[i]), 32'(exp_q[i]));

    // Readback always 00 on 3A: three writes, three reads, then on to the next entry.
    clear_tbl_a();
    tbl_a[0] = 16'h1055; tbl_a[1] = 16'h3A04; tbl_a[2] = 16'h1177;
    run_a("retry", 1'b1, 8'h3A);
    check("retry_err_count3", 32'(err_count_a), 32'(3));
    check("retry_error", 32'(error_a), 32'(1));

    // Delay entry: compare the idle gap with and without a {FE,02} entry.
    clear_tbl_a();
    tbl_a[0] = 16'h1055; tbl_a[1] = 16'h1166;
    run_a("nodelay", 1'b0, 8'h00);
    g0 = (gap_q.size() > 2) ? gap_q[2] : 0;
    clear_tbl_a();
    tbl_a[0] = 16'h1055; tbl_a[1] = 16'hFE02; tbl_a[2] = 16'h1166;
    run_a("delay", 1'b0, 8'h00);
    g1 = (gap_q.size() > 2) ? gap_q[2] : 0;
    check("delay_gap_window", 32'(g1 - g0 >= 2 * Du && g1 - g0 <= 2 * Du + 4), 32'(1));

    // No end marker: walk all 256 zero-delay entries and stop at FF without wrapping.
    for (int i = 0; i < 256; i++) tbl_a[i] = 16'hFE00;
    run_a("full", 1'b0, 8'h00);
    check("full_tbl_addr", 32'(tbl_addr_a), 32'(8'hFF));

    for (int r = 0; r < 6; r++) begin
      clear_tbl_a();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 4) == 0) tbl_a[i] = {8'hFE, 8'($urandom_range(0, 3))};
        else tbl_a[i] = {8'h20 + 8'($urandom_range(0, 7)), 8'($urandom_range(0, 255))};
      end
      run_a("rand", 1'($urandom_range(0, 1)), 8'h20 + 8'($urandom_range(0, 7)));
    end

    // Slave never answers: timeout sets error, drops start and still finishes.
    clear_tbl_a();
    tbl_a[0] = 16'h2001;
    hang_a = 1'b1;
    @(negedge xclk); go_a = 1'b1;
    @(negedge xclk); go_a = 1'b0;
    wait_init_a(Pwrup + Tmo + 200, ok);
    el = cyc - rise_cyc_a;
    check("tmo_finished", 32'(ok), 32'(1));
    check("tmo_error", 32'(error_a), 32'(1));
    check("tmo_start", 32'(start_a), 32'(0));
    check("tmo_elapsed", 32'(el >= Tmo - 1 && el <= Tmo + 3), 32'(1));
    hang_a = 1'b0;

    // Reset in the middle of a request, then a clean restart from entry 0.
    clear_tbl_a();
    tbl_a[0] = 16'h3011; tbl_a[1] = 16'h3122;
    bad_en_a = 1'b0;
    @(negedge xclk); go_a = 1'b1;
    @(negedge xclk); go_a = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge xclk);
      ok = start_a;
    end
    check("rst_saw_start", 32'(ok), 32'(1));
    #1 rst = 1'b1;
    #1 check_reset_a("midrst");
    @(negedge xclk); rst = 1'b0;
    run_a("after_rst", 1'b0, 8'h00);

    check("handshake_protocol", 32'(proto_err_a), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
